mips_if_id_stage: RTL and testbench
===================================

Name: mips_if_id_stage

Overview:
- Parametrised successor to the IF/ID pipeline register. Carries PC+4 and the fetched instruction from IF to ID using a valid/ready handshake in place of a bare write-enable.
- Optional 2-entry skid buffer so upstream ready is registered.
- Synchronous flush that converts in-flight slots to NOP bubbles.
- Saturating stall counter for performance monitoring.
- Sits between the fetch adder/instruction memory and the decode/hazard unit.

Parameters:
- PC_W, 32, width of PC+4 payload.
- INSTR_W, 32, width of instruction payload.
- NOP_INSTR, 0 (INSTR_W bits), value driven on out_instr for bubbles and flushed slots.
- SKID, 1, 1 = registered in_ready with skid entry; 0 = single register with combinational ready.
- CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous, active-low reset.
- in_valid  in  1  IF presents a slot.
- in_ready  out  1  stage can accept a slot.
- in_pc  in  PC_W  PC+4 from adder.
- in_instr  in  INSTR_W  instruction from imem.
- flush  in  1  kill all held slots (branch taken / jump).
- out_valid  out  1  ID slot valid.
- out_ready  in  1  ID/hazard unit accepts the slot (0 = stall).
- out_pc  out  PC_W  PC+4 to ID.
- out_instr  out  INSTR_W  instruction to ID.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- stall_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (RST_N=0 at posedge, overrides all inputs):
  - state EMPTY; out_valid=0, out_pc=0, out_instr=NOP_INSTR, skid regs=0, stall_cnt=0.
  - in_ready=1 in the cycle after reset.
- Transfer definitions:
  - Input transfer: in_valid & in_ready at posedge.
  - Output transfer: out_valid & out_ready at posedge.
- Latency: 1 cycle in→out when not stalled. Full throughput of 1 slot/cycle.
- SKID=1 state machine. in_ready = (state != SKID), driven from a register.
  - EMPTY: input transfer → main<=in, FULL.
  - FULL, out_ready=1:
    - in_valid=1 → main<=in, stay FULL.
    - in_valid=0 → EMPTY.
  - FULL, out_ready=0:
    - in_valid=1 → skid<=in, SKID.
    - in_valid=0 → hold.
  - SKID: out_ready=1 → main<=skid, FULL. Otherwise hold both entries.
- SKID=0:
  - in_ready = !out_valid | out_ready, combinational. No skid registers.
  - States EMPTY/FULL only.
- Main register drives out_valid/out_pc/out_instr directly; no combinational input→output path.
- Entering EMPTY through a drain: out_valid=0, out_instr=NOP_INSTR, out_pc holds its last value.
- Flush (highest priority after reset):
  - Next state EMPTY; out_valid=0; out_instr=NOP_INSTR; skid entry discarded.
  - out_pc<=in_pc (legacy flush carries PC+4).
  - A same-cycle input transfer is consumed and discarded; IF must not replay it.
  - Flush while stalled (FULL or SKID with out_ready=0) still empties the stage.
- Stall/flush priority: flush wins over stall; reset wins over flush.
- Payload is never modified except by NOP substitution. No width conversion.
- stall_cnt:
  - Increments each posedge with out_valid=1 & out_ready=0.
  - Saturates at 2^CNT_W-1.
  - stall_clr has priority over increment in the same cycle.
  - Not affected by flush.
- Invariants (assertable):
  - no input transfer when in_ready=0;
  - out payload stable while out_valid=1 & out_ready=0;
  - SKID state is unreachable when SKID=0.

Decomposition:
- mips_pipe_pkg: state enum {EMPTY, FULL, SKID}, default NOP constant (32'h0000_0000), stall counter saturating-increment function.
- One natural sub-module: mips_pipe_skid (generic DATA_W valid/ready skid slot with flush). mips_if_id_stage instantiates it with DATA_W=PC_W+INSTR_W and adds NOP substitution and the counter.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with in_valid=1, in_instr=32'h8C010004 → out_valid=0, out_instr=0, out_pc=0, stall_cnt=0; in_ready=1 the cycle after release.
- Streaming: out_ready=1; slots pc=4,8,12, instr=A,B,C on consecutive cycles → each appears exactly 1 cycle later, in order, with no gaps.
- Backpressure (SKID=1):
  - Drop out_ready with FULL(pc=4) while pc=8 is offered → state SKID, in_ready=0, out holds pc=4, stall_cnt increments each stalled cycle.
  - Raise out_ready → pc=4 then pc=8 delivered, in_ready=1 again.
- Flush in SKID: state SKID, assert flush with in_pc=16 → next cycle out_valid=0, out_instr=0, out_pc=16, in_ready=1; neither held slot is ever delivered.
- SKID=0 build: out_ready=0 with FULL → in_ready=0 in the same cycle; raise out_ready with in_valid=1 → simultaneous pass-through, state stays FULL.
- Counter (CNT_W=4): stall 20 cycles → stall_cnt saturates at 15. Assert stall_clr together with a stalled cycle → 0. Assert RST_N=0 mid-stall → all outputs return to reset values.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and helpers for the MIPS pipeline-register slice.
package mips_pipe_pkg;

    // Occupancy of a pipeline slot: nothing held, main entry held, main + skid held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // All-zero word is "sll $0,$0,0", the canonical MIPS NOP.
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    // Saturating increment for counters up to 32 bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/mips_pipe_skid.sv
// Generic valid/ready pipeline slot with an optional skid entry and flush.
// SKID=1: in_ready comes straight from a flop; SKID=0: single entry with
// combinational ready. On flush the main data register captures in_data so
// the owner can forward a sideband value while the slot is marked invalid.
module mips_pipe_skid
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_xfer;
    logic              load_in;
    logic              load_skid;
    logic              load_from_skid;

    assign in_xfer   = in_valid & in_ready;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

    // Next-state and load-enable decode for the slot.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d        = state_q;
        load_in        = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    load_in = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (in_xfer) load_in = 1'b1;
                    else         state_d = ST_EMPTY;
                end else if (in_xfer) begin
                    // Only reachable with SKID=1: without a skid entry in_ready is low here.
                    load_skid = 1'b1;
                    state_d   = ST_SKID;
                end
            end
            ST_SKID: begin
                if (out_ready) begin
                    load_from_skid = 1'b1;
                    state_d        = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush discards everything, including a same-cycle input transfer.
        if (flush) begin
            state_d        = ST_EMPTY;
            load_in        = 1'b0;
            load_skid      = 1'b0;
            load_from_skid = 1'b0;
        end
    end

    // State register and main data entry.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            // NOTE: data registers are reset too, because a cleared PC is visible on the port after reset.
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            if (flush)               main_q <= in_data;
            else if (load_in)        main_q <= in_data;
            else if (load_from_skid) main_q <= skid_q;
        end
    end

    if (SKID) begin : g_skid
        logic ready_q;

        // Skid entry plus registered ready: ready drops only while the skid entry is occupied.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                skid_q  <= '0;
                ready_q <= 1'b1;
            end else begin
                ready_q <= (state_d != ST_SKID);
                if (load_skid) skid_q <= in_data;
            end
        end

        assign in_ready = ready_q;
    end else begin : g_noskid
        assign skid_q   = '0;
        assign in_ready = (state_q == ST_EMPTY) | out_ready;
    end

endmodule

// File: rtl/mips_if_id_stage.sv
// IF/ID pipeline register with valid/ready handshake, flush-to-NOP and a
// saturating stall counter. Payload is {PC+4, instruction}.
module mips_if_id_stage
    import mips_pipe_pkg::*;
#(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_DEFAULT),
    parameter bit                 SKID      = 1'b1,
    parameter int                 CNT_W     = 16   // at most 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_cnt,
    input  logic               stall_clr
);

    localparam int DATA_W = PC_W + INSTR_W;

    logic [DATA_W-1:0]  slot_data;
    logic [INSTR_W-1:0] held_instr;

    mips_pipe_skid #(
        .DATA_W (DATA_W),
        .SKID   (SKID)
    ) u_slot (
        .clk       (CLK),
        .rst_n     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_pc, in_instr}),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (slot_data)
    );

    // PC always follows the held entry (drains keep it, flush loads in_pc);
    // the instruction is masked to NOP whenever the slot is a bubble.
    assign out_pc     = slot_data[DATA_W-1:INSTR_W];
    assign held_instr = slot_data[INSTR_W-1:0];
    assign out_instr  = out_valid ? held_instr : NOP_INSTR;

    // Stall counter: clear beats increment, saturates at all-ones, ignores flush.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= CNT_W'(sat_inc(32'(stall_cnt), 32'({CNT_W{1'b1}})));
        end
    end

endmodule

// File: tb/tb_mips_if_id_stage.sv
// Directed bench for mips_if_id_stage: a SKID=1/CNT_W=4 instance driven from a
// vector table plus hand sequences, and a SKID=0 instance for combinational ready.
module tb_mips_if_id_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: SKID=1, 4-bit counter.
    logic        rst_n, a_iv, a_fl, a_or, a_clr;
    logic [31:0] a_ipc, a_iins;
    logic        a_ir, a_ov;
    logic [31:0] a_opc, a_oins;
    logic [3:0]  a_cnt;

    // Instance B: SKID=0, 16-bit counter.
    logic        b_iv, b_fl, b_or, b_clr;
    logic [31:0] b_ipc, b_iins;
    logic        b_ir, b_ov;
    logic [31:0] b_opc, b_oins;
    logic [15:0] b_cnt;

    mips_if_id_stage #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h0), .SKID(1'b1), .CNT_W(4)) dut_a (
        .CLK(clk), .RST_N(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_pc(a_ipc),
        .in_instr(a_iins), .flush(a_fl), .out_valid(a_ov), .out_ready(a_or),
        .out_pc(a_opc), .out_instr(a_oins), .stall_cnt(a_cnt), .stall_clr(a_clr)
    );

    mips_if_id_stage #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h0), .SKID(1'b0), .CNT_W(16)) dut_b (
        .CLK(clk), .RST_N(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_pc(b_ipc),
        .in_instr(b_iins), .flush(b_fl), .out_valid(b_ov), .out_ready(b_or),
        .out_pc(b_opc), .out_instr(b_oins), .stall_cnt(b_cnt), .stall_clr(b_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs applied during a cycle, and outputs expected during that same
    // cycle (i.e. the result of the previous edges).
    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] iins;
        logic        fl;
        logic        ordy;
        logic        clr;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [3:0]  e_cnt;
    } vec_t;

    localparam logic [31:0] IA = 32'hAAAA_0001, IB = 32'hBBBB_0002, IC = 32'hCCCC_0003;
    localparam logic [31:0] ID = 32'hDDDD_0005, IE = 32'hEEEE_0006, IF = 32'hFFFF_0004;
    localparam logic [31:0] IG = 32'h1111_0007, IH = 32'h2222_0008;

    vec_t vecs[20];

    initial begin
        //           rst   iv    ipc    iins          fl    ordy  clr   e_ir  e_ov  e_pc   e_ins  e_cnt
        // third reset cycle: reset state visible
        vecs[0]  = '{1'b0, 1'b1, 32'd4,  32'h8C010004, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0,  32'h0, 4'd0};
        // streaming 4,8,12 with no gaps
        vecs[1]  = '{1'b1, 1'b1, 32'd4,  IA,           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0,  32'h0, 4'd0};
        vecs[2]  = '{1'b1, 1'b1, 32'd8,  IB,           1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd4,  IA,    4'd0};
        vecs[3]  = '{1'b1, 1'b1, 32'd12, IC,           1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd8,  IB,    4'd0};
        vecs[4]  = '{1'b1, 1'b0, 32'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd12, IC,    4'd0};
        // drained: bubble, pc holds
        vecs[5]  = '{1'b1, 1'b0, 32'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd12, 32'h0, 4'd0};
        // backpressure into skid
        vecs[6]  = '{1'b1, 1'b1, 32'd4,  IA,           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd12, 32'h0, 4'd0};
        vecs[7]  = '{1'b1, 1'b1, 32'd8,  IB,           1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd4,  IA,    4'd0};
        vecs[8]  = '{1'b1, 1'b1, 32'd12, IC,           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4,  IA,    4'd1};
        vecs[9]  = '{1'b1, 1'b1, 32'd12, IC,           1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd4,  IA,    4'd2};
        vecs[10] = '{1'b1, 1'b0, 32'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd8,  IB,    4'd2};
        vecs[11] = '{1'b1, 1'b0, 32'd0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd8,  32'h0, 4'd2};
        // flush while in SKID state
        vecs[12] = '{1'b1, 1'b1, 32'd20, ID,           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd8,  32'h0, 4'd0};
        vecs[13] = '{1'b1, 1'b1, 32'd24, IE,           1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd20, ID,    4'd0};
        vecs[14] = '{1'b1, 1'b0, 32'd16, IF,           1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd20, ID,    4'd1};
        vecs[15] = '{1'b1, 1'b0, 32'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd16, 32'h0, 4'd2};
        vecs[16] = '{1'b1, 1'b0, 32'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd16, 32'h0, 4'd2};
        // flush with a same-cycle input transfer: transfer is discarded
        vecs[17] = '{1'b1, 1'b1, 32'd28, IG,           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd16, 32'h0, 4'd2};
        vecs[18] = '{1'b1, 1'b1, 32'd32, IH,           1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd28, IG,    4'd2};
        vecs[19] = '{1'b1, 1'b0, 32'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd32, 32'h0, 4'd2};

        // Reset asserted with a live slot offered to both instances.
        rst_n = 1'b0;
        a_iv = 1'b1; a_ipc = 32'd4; a_iins = 32'h8C010004; a_fl = 1'b0; a_or = 1'b1; a_clr = 1'b0;
        b_iv = 1'b1; b_ipc = 32'd4; b_iins = 32'h8C010004; b_fl = 1'b0; b_or = 1'b1; b_clr = 1'b0;
        @(negedge clk);
        b_iv = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            a_iv  = vecs[i].iv;   a_ipc = vecs[i].ipc;  a_iins = vecs[i].iins;
            a_fl  = vecs[i].fl;   a_or  = vecs[i].ordy; a_clr  = vecs[i].clr;
            #1;
            check($sformatf("v%0d in_ready", i),  32'(a_ir),  32'(vecs[i].e_ir));
            check($sformatf("v%0d out_valid", i), 32'(a_ov),  32'(vecs[i].e_ov));
            check($sformatf("v%0d out_pc", i),    a_opc,      vecs[i].e_pc);
            check($sformatf("v%0d out_instr", i), a_oins,     vecs[i].e_ins);
            check($sformatf("v%0d stall_cnt", i), 32'(a_cnt), 32'(vecs[i].e_cnt));
        end

        // Counter saturation: load pc=40 and clear, then stall 20 cycles.
        @(negedge clk);
        a_iv = 1'b1; a_ipc = 32'd40; a_iins = 32'h3333_0009; a_fl = 1'b0; a_or = 1'b1; a_clr = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            a_iv = 1'b0; a_or = 1'b0; a_clr = 1'b0;
            #1;
            check($sformatf("sat%0d stall_cnt", k), 32'(a_cnt), (k < 15) ? 32'(k) : 32'd15);
            check($sformatf("sat%0d out_pc stable", k), a_opc, 32'd40);
            check($sformatf("sat%0d out_valid", k), 32'(a_ov), 32'd1);
        end
        // Clear during a stalled cycle wins over the increment.
        @(negedge clk);
        a_clr = 1'b1;
        #1;
        check("sat final stall_cnt", 32'(a_cnt), 32'd15);
        @(negedge clk);
        a_clr = 1'b0;
        #1;
        check("clr stall_cnt", 32'(a_cnt), 32'd0);
        check("clr out_instr held", a_oins, 32'h3333_0009);
        // Reset in the middle of a stall with a slot offered.
        @(negedge clk);
        rst_n = 1'b0; a_iv = 1'b1; a_ipc = 32'd44; a_iins = 32'h4444_000A;
        #1;
        check("pre-rst stall_cnt", 32'(a_cnt), 32'd1);
        @(negedge clk);
        rst_n = 1'b1; a_iv = 1'b0; a_or = 1'b1;
        #1;
        check("midrst out_valid", 32'(a_ov),  32'd0);
        check("midrst out_pc",    a_opc,      32'd0);
        check("midrst out_instr", a_oins,     32'd0);
        check("midrst stall_cnt", 32'(a_cnt), 32'd0);
        check("midrst in_ready",  32'(a_ir),  32'd1);

        // SKID=0 instance: combinational ready and pass-through while FULL.
        @(negedge clk);
        b_iv = 1'b1; b_ipc = 32'd4; b_iins = IA; b_or = 1'b1;
        #1;
        check("b idle in_ready", 32'(b_ir), 32'd1);
        check("b idle out_valid", 32'(b_ov), 32'd0);
        @(negedge clk);
        b_ipc = 32'd8; b_iins = IB; b_or = 1'b0;
        #1;
        check("b stall in_ready", 32'(b_ir), 32'd0);
        check("b stall out_pc", b_opc, 32'd4);
        check("b stall out_instr", b_oins, IA);
        @(negedge clk);
        b_or = 1'b1;
        #1;
        check("b release in_ready", 32'(b_ir), 32'd1);
        check("b release out_pc", b_opc, 32'd4);
        check("b stall_cnt", 32'(b_cnt), 32'd1);
        @(negedge clk);
        b_iv = 1'b0;
        #1;
        check("b pass out_valid", 32'(b_ov), 32'd1);
        check("b pass out_pc", b_opc, 32'd8);
        check("b pass out_instr", b_oins, IB);
        @(negedge clk);
        #1;
        check("b drain out_valid", 32'(b_ov), 32'd0);
        check("b drain out_pc", b_opc, 32'd8);
        check("b drain out_instr", b_oins, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
